rst_seq: RTL and testbench
==========================

# rst_seq

Reset sequencer that generates the design's reset outputs: it holds N_OUT active-low reset outputs low for a minimum pulse width, then releases them one at a time in a fixed order. Beyond power-on, it accepts software and watchdog reset requests and reports when a software-requested sequence has completed. It sits directly after the top-level reset synchronizer and drives the per-subsystem resets (e.g. core, bus, peripherals).

## Interface
- N_OUT, 3, number of sequenced reset outputs, ≥1
- HOLD_CYC, 16, cycles all outputs stay low before the first release, ≥1
- STEP_CYC, 4, cycles between consecutive output releases, ≥1

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low; already release-synchronous to clk
- sw_rst_req  in  1  software reset request, level; the rising edge triggers
- wdt_rst  in  1  watchdog reset, level; high = keep triggering
- rst_n_out  out  N_OUT  sequenced active-low resets; bit 0 released first
- busy  out  1  high while any rst_n_out bit is low
- sw_rst_ack  out  1  one-cycle pulse when a software-triggered sequence completes
- rst_cause  out  2  last reset cause: 00 POR, 01 SW, 10 WDT

## Operation
- States: HOLD (all outputs 0, counting HOLD_CYC), REL (releasing outputs, counting STEP_CYC per bit), RUN (all outputs 1).
- rst_n low, asynchronously: state=HOLD, cnt=0, idx=0, rst_n_out=0, busy=1, sw_rst_ack=0, rst_cause=00, sw edge register=0, sw pending flag=0.
- Trigger: `trig = wdt_rst | (sw_rst_req & ~sw_rst_req_q)`. Trigger is valid in every state.
- On trigger at posedge t:
  - rst_n_out=0 and busy=1 after the edge.
  - state=HOLD, cnt=0, idx=0.
  - Released bits are re-asserted.
  - The HOLD/REL sequence restarts from the beginning.
- HOLD: cnt increments each cycle. When cnt reaches HOLD_CYC-1, bit 0 is set, and the block enters REL with cnt=0 (or enters RUN if N_OUT=1).
- REL: cnt increments. When cnt reaches STEP_CYC-1, the next bit idx+1 is set and cnt=0. Setting bit N_OUT-1 enters RUN.
- Released bits only go 0→1, in index order; bits never release out of order.
- RUN: all bits 1, busy=0, counters idle.
- Pending flag:
  - Set by a SW trigger; cleared by a WDT trigger.
  - When pending=1 at entry to RUN, sw_rst_ack=1 for exactly that one cycle and pending clears.
- Simultaneous SW edge and wdt_rst: the event is treated as WDT; cause=10 and pending=0.
- wdt_rst held high keeps the block in HOLD with cnt=0 and outputs low.
- sw_rst_req already high at reset release counts as a rising edge in the first cycle, so the hold restarts one cycle later.
- Counter width is $clog2(max(HOLD_CYC,STEP_CYC)+1). idx width is $clog2(N_OUT+1).

## Timing
- All outputs are registered. Reset assertion by rst_n is asynchronous; all other transitions are synchronous to posedge clk.
- With rst_n released before posedge 1 (no triggers), rst_n_out[k] rises at posedge HOLD_CYC + k·STEP_CYC.
- busy falls at the same edge as rst_n_out[N_OUT-1].
- A trigger sampled at posedge t drives outputs low after t. rst_n_out[k] then rises at t + HOLD_CYC + k·STEP_CYC.
- sw_rst_ack is high in the cycle after the edge where busy falls.
- Minimum low pulse on any output is HOLD_CYC cycles, including when a trigger arrives mid-REL.

## Configuration
- RST_SEQ_CAUSE_EN defined: rst_cause is a register. It resets to 00 and loads 01 or 10 on a SW or WDT trigger; the value holds through HOLD, REL and RUN.
- RST_SEQ_CAUSE_EN undefined: no cause register exists and rst_cause is constant 00. All other behaviour, including sw_rst_ack, is identical.

## Test plan
- POR, defaults: release rst_n before posedge 1 → rst_n_out goes 000→001 at edge 16, →011 at 20, →111 at 24; busy falls at 24; no ack.
- SW request: in RUN, raise sw_rst_req at edge 40 and hold high → outputs 000 after 40, 111 at 64. sw_rst_ack pulses once after 64. rst_cause=01 with macro, 00 without. No retrigger while the request stays high.
- WDT mid-release: after rst_n_out=001 at edge 16, pulse wdt_rst at edge 18 → outputs 000 after 18, 001 at 34, 111 at 42; rst_cause=10 with macro.
- Simultaneous: SW edge and wdt_rst at the same edge → rst_cause=10 and no sw_rst_ack at completion. Separately, wdt_rst held for 30 cycles → outputs stay 000 throughout.
- Async reset mid-sequence: drop rst_n during REL → outputs 000 and busy=1 immediately, without waiting for clk. rst_cause=00, a pending ack is discarded, and the POR timing then repeats.
- Parameter sweep: N_OUT=1, HOLD_CYC=1, STEP_CYC=1 → the output rises at edge 1 and busy falls at edge 1. N_OUT=4, HOLD_CYC=3, STEP_CYC=2 → outputs rise at edges 3, 5, 7, 9.

Source files
------------

// File: rtl/rst_seq.sv
// Reset sequencer: holds all subsystem resets low, then releases them one by one in index order.
// Optional RST_SEQ_CAUSE_EN keeps a register with the last reset cause; without it rst_cause is 00.
module rst_seq #(
  parameter int N_OUT    = 3,
  parameter int HOLD_CYC = 16,
  parameter int STEP_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_rst_req,
  input  logic             wdt_rst,
  output logic [N_OUT-1:0] rst_n_out,
  output logic             busy,
  output logic             sw_rst_ack,
  output logic [1:0]       rst_cause,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_REL  = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  localparam int CMAX = (HOLD_CYC > STEP_CYC) ? HOLD_CYC : STEP_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(N_OUT + 1);

  localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0]    STEP_LAST = CW'(STEP_CYC - 1);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(N_OUT - 1);
  localparam logic [N_OUT-1:0] OUT_ONE   = N_OUT'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_OUT-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             pend_q, pend_d;
  logic             sw_q;
  logic             sw_edge;
  logic             trig;

  assign sw_edge = sw_rst_req & ~sw_q;
  assign trig    = wdt_rst | sw_edge;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = out_q;
    ack_d   = 1'b0;
    pend_d  = pend_q;

    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          out_d = OUT_ONE;
          cnt_d = '0;
          idx_d = '0;
          if (N_OUT == 1) begin
            state_d = S_RUN;
            ack_d   = pend_q;
            pend_d  = 1'b0;
          end else begin
            state_d = S_REL;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REL: begin
        if (cnt_q == STEP_LAST) begin
          // Shifting a one in from bit 0 guarantees in-order release.
          out_d = (out_q << 1) | OUT_ONE;
          cnt_d = '0;
          idx_d = idx_q + IW'(1);
          if (idx_d == IDX_LAST) begin
            state_d = S_RUN;
            ack_d   = pend_q;
            pend_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        cnt_d = '0;
        idx_d = '0;
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        out_d   = '0;
      end
    endcase

    // A trigger overrides everything; watchdog wins over a simultaneous SW edge.
    if (trig) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      out_d   = '0;
      ack_d   = 1'b0;
      pend_d  = ~wdt_rst;
    end

    busy_d = ~(&out_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      sw_q    <= sw_rst_req;
    end
  end

`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] cause_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q <= 2'b00;
    end else if (trig) begin
      cause_q <= wdt_rst ? 2'b10 : 2'b01;
    end
  end

  assign rst_cause = cause_q;
`else
  assign rst_cause = 2'b00;
`endif

  assign rst_n_out  = out_q;
  assign busy       = busy_q;
  assign sw_rst_ack = ack_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: default instance plus two parameter-sweep instances.
module tb_rst_seq;

  logic       clk;
  logic       rst_n;
  logic       sw_rst_req;
  logic       wdt_rst;
  logic       sw_zero;
  logic       wdt_zero;

  logic [2:0] out3;
  logic       busy3, ack3;
  logic [1:0] cause3, st3;
  logic [0:0] out1;
  logic       busy1, ack1;
  logic [1:0] cause1, st1;
  logic [3:0] out4;
  logic       busy4, ack4;
  logic [1:0] cause4, st4;

  int n_checks = 0;
  int n_errors = 0;
  int ecnt     = 0;

`ifdef RST_SEQ_CAUSE_EN
  localparam int C_SW  = 1;
  localparam int C_WDT = 2;
`else
  localparam int C_SW  = 0;
  localparam int C_WDT = 0;
`endif

  rst_seq #(.N_OUT(3), .HOLD_CYC(16), .STEP_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .wdt_rst(wdt_rst),
    .rst_n_out(out3), .busy(busy3), .sw_rst_ack(ack3), .rst_cause(cause3), .dbg_state(st3)
  );

  rst_seq #(.N_OUT(1), .HOLD_CYC(1), .STEP_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_zero), .wdt_rst(wdt_zero),
    .rst_n_out(out1), .busy(busy1), .sw_rst_ack(ack1), .rst_cause(cause1), .dbg_state(st1)
  );

  rst_seq #(.N_OUT(4), .HOLD_CYC(3), .STEP_CYC(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_zero), .wdt_rst(wdt_zero),
    .rst_n_out(out4), .busy(busy4), .sw_rst_ack(ack4), .rst_cause(cause4), .dbg_state(st4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, ecnt, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic at_edge(input int e);
    while (ecnt < e) step();
  endtask

  task automatic check_main(input string tag, input int out_e, input int busy_e);
    check({tag, "_out"},  32'(out3),  32'(out_e));
    check({tag, "_busy"}, 32'(busy3), 32'(busy_e));
  endtask

  // Drop rst_n mid-cycle, confirm the asynchronous effect, release before the next edge 1.
  task automatic async_restart();
    #3 rst_n = 1'b0;
    #2;
    check("async_out",   32'(out3),   0);
    check("async_busy",  32'(busy3),  1);
    check("async_ack",   32'(ack3),   0);
    check("async_cause", 32'(cause3), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ecnt  = 0;
  endtask

  initial begin
    rst_n      = 1'b0;
    sw_rst_req = 1'b0;
    wdt_rst    = 1'b0;
    sw_zero    = 1'b0;
    wdt_zero   = 1'b0;
    #12;
    check_main("rst", 0, 1);
    check("rst_ack",   32'(ack3),   0);
    check("rst_cause", 32'(cause3), 0);
    check("rst_state", 32'(st3),    0);
    check("rst_out1",  32'(out1),   0);
    check("rst_out4",  32'(out4),   0);
    @(negedge clk);
    rst_n = 1'b1;
    ecnt  = 0;

    // POR with parameter sweep instances
    at_edge(1);
    check("n1_out", 32'(out1), 1);  check("n1_busy", 32'(busy1), 0);
    check("n4_out_e1", 32'(out4), 0);
    at_edge(2);  check("n4_out_e2", 32'(out4), 0);
    at_edge(3);  check("n4_out_e3", 32'(out4), 1);
    at_edge(4);  check("n4_out_e4", 32'(out4), 1);
    at_edge(5);  check("n4_out_e5", 32'(out4), 3);
    at_edge(7);  check("n4_out_e7", 32'(out4), 7);
    at_edge(8);  check("n4_busy_e8", 32'(busy4), 1);
    at_edge(9);  check("n4_out_e9", 32'(out4), 15); check("n4_busy_e9", 32'(busy4), 0);
    at_edge(15); check_main("por15", 0, 1);
    at_edge(16); check_main("por16", 1, 1);
    at_edge(19); check_main("por19", 1, 1);
    at_edge(20); check_main("por20", 3, 1);
    at_edge(23); check_main("por23", 3, 1);
    at_edge(24); check_main("por24", 7, 0); check("por_ack24", 32'(ack3), 0);
    at_edge(25); check("por_ack25", 32'(ack3), 0); check("por_cause", 32'(cause3), 0);
    check("por_state", 32'(st3), 2);

    // SW request held high from edge 40
    at_edge(39); sw_rst_req = 1'b1;
    at_edge(40); check_main("sw40", 0, 1); check("sw_cause", 32'(cause3), C_SW);
    at_edge(55); check_main("sw55", 0, 1);
    at_edge(56); check_main("sw56", 1, 1);
    at_edge(60); check_main("sw60", 3, 1);
    at_edge(63); check_main("sw63", 3, 1); check("sw_ack63", 32'(ack3), 0);
    at_edge(64); check_main("sw64", 7, 0); check("sw_ack64", 32'(ack3), 1);
    at_edge(65); check("sw_ack65", 32'(ack3), 0);
    at_edge(80); check_main("sw_hold80", 7, 0); check("sw_ack80", 32'(ack3), 0);
    sw_rst_req = 1'b0;

    // SW sequence interrupted by async reset during REL; pending ack must be discarded
    at_edge(89); sw_rst_req = 1'b1;
    at_edge(90); sw_rst_req = 1'b0;
    at_edge(106); check_main("pre_async106", 1, 1);
    at_edge(108); check_main("pre_async108", 1, 1);
    async_restart();
    at_edge(16); check_main("rpor16", 1, 1);
    at_edge(24); check_main("rpor24", 7, 0); check("rpor_ack24", 32'(ack3), 0);
    at_edge(25); check("rpor_ack25", 32'(ack3), 0); check("rpor_cause", 32'(cause3), 0);

    // WDT pulse mid-release
    async_restart();
    at_edge(16); check_main("wdt16", 1, 1);
    at_edge(17); wdt_rst = 1'b1;
    at_edge(18); wdt_rst = 1'b0;
    check_main("wdt18", 0, 1); check("wdt_cause", 32'(cause3), C_WDT);
    at_edge(33); check_main("wdt33", 0, 1);
    at_edge(34); check_main("wdt34", 1, 1);
    at_edge(38); check_main("wdt38", 3, 1);
    at_edge(41); check_main("wdt41", 3, 1);
    at_edge(42); check_main("wdt42", 7, 0); check("wdt_ack42", 32'(ack3), 0);
    at_edge(43); check("wdt_ack43", 32'(ack3), 0);

    // Simultaneous SW edge and WDT: treated as WDT, no ack
    at_edge(49); sw_rst_req = 1'b1; wdt_rst = 1'b1;
    at_edge(50); sw_rst_req = 1'b0; wdt_rst = 1'b0;
    check_main("sim50", 0, 1); check("sim_cause", 32'(cause3), C_WDT);
    at_edge(66); check_main("sim66", 1, 1);
    at_edge(74); check_main("sim74", 7, 0); check("sim_ack74", 32'(ack3), 0);
    at_edge(75); check("sim_ack75", 32'(ack3), 0);

    // WDT held for 30 cycles keeps everything low
    at_edge(79); wdt_rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      check("wdt_held_out", 32'(out3), 0);
    end
    wdt_rst = 1'b0;
    at_edge(124); check_main("whr124", 0, 1);
    at_edge(125); check_main("whr125", 1, 1);
    at_edge(133); check_main("whr133", 7, 0); check("whr_cause", 32'(cause3), C_WDT);

    // SW request already high at reset release restarts the hold one cycle late
    sw_rst_req = 1'b1;
    async_restart();
    at_edge(16); check_main("swr16", 0, 1);
    at_edge(17); check_main("swr17", 1, 1);
    at_edge(24); check_main("swr24", 3, 1);
    at_edge(25); check_main("swr25", 7, 0); check("swr_ack25", 32'(ack3), 1);
    check("swr_cause", 32'(cause3), C_SW);
    at_edge(26); check("swr_ack26", 32'(ack3), 0);
    sw_rst_req = 1'b0;

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
